// File: rtl/draw_background_frame_if.sv
// Pixel-stream bundle between the VGA timing chain and the border painter.
// The stream has no valid/ready pair: every pclk carries one pixel and the painter never stalls.
interface draw_background_frame_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic        alert;
  logic [3:0]  border_en;

  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        frame_tick;

  // Flash controller visibility: state (0=NORMAL, 1=FLASH), phase and latched alert
  logic        dbg_state;
  logic        dbg_phase;
  logic        dbg_alert_q;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, alert, border_en,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, frame_tick, dbg_state, dbg_phase, dbg_alert_q
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, alert, border_en,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, frame_tick, dbg_state, dbg_phase, dbg_alert_q
  );
endinterface

// File: rtl/draw_background_frame.sv
// Border/background painter: 2-stage pipeline over the VGA stream with a
// frame-synchronous flashing side border driven by the alert input.
module draw_background_frame #(
  parameter int          H_ACTIVE     = 800,
  parameter int          V_ACTIVE     = 600,
  parameter int          BORDER       = 9,
  parameter int          FLASH_FRAMES = 30,
  parameter logic [11:0] COLOR_BORDER = 12'h888,
  parameter logic [11:0] COLOR_ALERT  = 12'hF00,
  parameter logic [11:0] COLOR_BOTTOM = 12'h000
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  draw_background_frame_if.slave   bus
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [10:0]      TOP_END     = 11'(BORDER);
  localparam logic [10:0]      LEFT_END    = 11'(BORDER);
  localparam logic [10:0]      RIGHT_START = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0]      BOT_START   = 11'(V_ACTIVE - BORDER);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FLASH  = 1'b1
  } flash_state_t;

  // Stage 1
  logic [10:0] r1_hcount, r1_vcount;
  logic        r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic [11:0] r1_rgb;
  logic        r1_top, r1_bottom, r1_left, r1_right;
  logic [3:0]  r1_en;
  logic        r1_edge;

  // Stage 2
  logic [10:0] r2_hcount, r2_vcount;
  logic        r2_hsync, r2_vsync, r2_hblnk, r2_vblnk;
  logic [11:0] r2_rgb;
  logic        r2_tick;

  // Flash controller
  flash_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic             r_alert_q;

  logic        w_frame_edge;
  logic [11:0] w_border_color;
  logic [11:0] w_rgb;

  assign w_frame_edge = bus.vblnk_in & ~r1_vblnk;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r1_hcount <= '0;
      r1_vcount <= '0;
      r1_hsync  <= 1'b0;
      r1_vsync  <= 1'b0;
      r1_hblnk  <= 1'b0;
      r1_vblnk  <= 1'b0;
      r1_rgb    <= '0;
      r1_top    <= 1'b0;
      r1_bottom <= 1'b0;
      r1_left   <= 1'b0;
      r1_right  <= 1'b0;
      r1_en     <= '0;
      r1_edge   <= 1'b0;
    end else begin
      r1_hcount <= bus.hcount_in;
      r1_vcount <= bus.vcount_in;
      r1_hsync  <= bus.hsync_in;
      r1_vsync  <= bus.vsync_in;
      r1_hblnk  <= bus.hblnk_in;
      r1_vblnk  <= bus.vblnk_in;
      r1_rgb    <= bus.rgb_in;
      r1_top    <= bus.vcount_in <  TOP_END;
      r1_bottom <= bus.vcount_in >= BOT_START;
      r1_left   <= bus.hcount_in <  LEFT_END;
      r1_right  <= bus.hcount_in >= RIGHT_START;
      r1_en     <= bus.border_en;
      r1_edge   <= w_frame_edge;
    end
  end

  // Phase only moves on a vblnk rising edge, so the colour never changes mid-picture
  assign w_border_color = r_phase ? COLOR_ALERT : COLOR_BORDER;

  always_comb begin
    w_rgb = r1_rgb;
    if (r1_hblnk | r1_vblnk)        w_rgb = 12'h000;
    else if (r1_top   & r1_en[3])   w_rgb = w_border_color;
    else if (r1_left  & r1_en[1])   w_rgb = w_border_color;
    else if (r1_right & r1_en[0])   w_rgb = w_border_color;
    else if (r1_bottom & r1_en[2])  w_rgb = COLOR_BOTTOM;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r2_hcount <= '0;
      r2_vcount <= '0;
      r2_hsync  <= 1'b0;
      r2_vsync  <= 1'b0;
      r2_hblnk  <= 1'b0;
      r2_vblnk  <= 1'b0;
      r2_rgb    <= '0;
      r2_tick   <= 1'b0;
    end else begin
      r2_hcount <= r1_hcount;
      r2_vcount <= r1_vcount;
      r2_hsync  <= r1_hsync;
      r2_vsync  <= r1_vsync;
      r2_hblnk  <= r1_hblnk;
      r2_vblnk  <= r1_vblnk;
      r2_rgb    <= w_rgb;
      r2_tick   <= r1_edge;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_NORMAL;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_alert_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      if (w_frame_edge) r_alert_q <= bus.alert;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (w_frame_edge) begin
      case (r_state)
        ST_NORMAL: begin
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b0;
          if (bus.alert) w_state_nxt = ST_FLASH;
        end
        ST_FLASH: begin
          if (!bus.alert) begin
            w_state_nxt = ST_NORMAL;
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_NORMAL;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.hcount_out  = r2_hcount;
  assign bus.vcount_out  = r2_vcount;
  assign bus.hsync_out   = r2_hsync;
  assign bus.vsync_out   = r2_vsync;
  assign bus.hblnk_out   = r2_hblnk;
  assign bus.vblnk_out   = r2_vblnk;
  assign bus.rgb_out     = r2_rgb;
  assign bus.frame_tick  = r2_tick;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_phase   = r_phase;
  assign bus.dbg_alert_q = r_alert_q;

endmodule

// File: tb/tb_draw_background_frame.sv
// Directed bench for draw_background_frame: reset, regions, enables, flashing,
// mid-flash reset and pass-through alignment against a 2-cycle reference.
module tb_draw_background_frame;

  logic pclk;
  logic rst_n;
  int   total;
  int   bad;

  draw_background_frame_if bus ();

  draw_background_frame #(
    .FLASH_FRAMES(2)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Driver tasks
  task automatic set_in(input logic [10:0] h, input logic [10:0] v, input logic hs,
                        input logic vs, input logic hb, input logic vb,
                        input logic [11:0] rgb);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    bus.hblnk_in  = hb;
    bus.vblnk_in  = vb;
    bus.rgb_in    = rgb;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Region vectors: h, v, hblnk, vblnk, expected rgb with border_en=F, rgb_in=123
  logic [10:0] reg_h   [9] = '{11'd4,   11'd400, 11'd400, 11'd791, 11'd790, 11'd400, 11'd400, 11'd4,   11'd400};
  logic [10:0] reg_v   [9] = '{11'd300, 11'd8,   11'd9,   11'd300, 11'd300, 11'd595, 11'd300, 11'd595, 11'd300};
  logic        reg_hb  [9] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
  logic        reg_vb  [9] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
  logic [11:0] reg_exp [9] = '{12'h888, 12'h888, 12'h123, 12'h888, 12'h123, 12'h000, 12'h000, 12'h888, 12'h000};

  // Side-enable vectors: border_en, h, v, expected rgb with rgb_in=123
  logic [3:0]  se_en  [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
  logic [10:0] se_h   [5] = '{11'd4,   11'd400, 11'd400, 11'd791, 11'd4};
  logic [10:0] se_v   [5] = '{11'd300, 11'd591, 11'd8,   11'd300, 11'd5};
  logic [11:0] se_exp [5] = '{12'h123, 12'h000, 12'h123, 12'h123, 12'h888};

  // Border colour seen in the frame after each of 7 edges with alert held, FLASH_FRAMES=2
  logic [11:0] flash_exp [7] = '{12'h888, 12'h888, 12'hF00, 12'hF00, 12'h888, 12'h888, 12'hF00};

  // Scoreboard for the pass-through stream: {h, v, hs, vs, hb, vb, tick, rgb}
  logic [38:0] exp_q[$];

  task automatic test_reset();
    logic [37:0] outs;
    rst_n = 1'b0;
    bus.alert = 1'b1;
    bus.border_en = 4'hF;
    set_in(11'd55, 11'd77, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF);
    cyc(3);
    outs = {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
            bus.hblnk_out, bus.vblnk_out, bus.rgb_out, bus.frame_tick};
    total++;
    if (outs !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    total++;
    if ({bus.dbg_state, bus.dbg_phase, bus.dbg_alert_q} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flash_state got=%b exp=000", {bus.dbg_state, bus.dbg_phase, bus.dbg_alert_q});
    end
    bus.alert = 1'b0;
    bus.border_en = 4'h0;
    set_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    rst_n = 1'b1;
    cyc(1);
    set_in(11'd123, 11'd45, 1'b1, 1'b0, 1'b0, 1'b0, 12'hABC);
    cyc(1);
    total++;
    if (bus.hcount_out !== 11'd0) begin
      bad++;
      $display("FAIL latency_n+1 hcount_out got=%0d exp=0", bus.hcount_out);
    end
    set_in(11'd200, 11'd46, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
    cyc(1);
    total++;
    if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.rgb_out} !== {11'd123, 11'd45, 1'b1, 12'hABC}) begin
      bad++;
      $display("FAIL latency_n+2_a got=%0d/%0d/%b/%h exp=123/45/1/abc",
               bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.rgb_out);
    end
    cyc(1);
    total++;
    if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.rgb_out} !== {11'd200, 11'd46, 1'b0, 12'h456}) begin
      bad++;
      $display("FAIL latency_n+2_b got=%0d/%0d/%b/%h exp=200/46/0/456",
               bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.rgb_out);
    end
  endtask

  task automatic test_regions();
    bus.border_en = 4'hF;
    bus.alert = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_in(reg_h[i], reg_v[i], 1'b0, 1'b0, reg_hb[i], reg_vb[i], 12'h123);
      cyc(2);
      total++;
      if (bus.rgb_out !== reg_exp[i]) begin
        bad++;
        $display("FAIL region[%0d] h=%0d v=%0d rgb_out got=%h exp=%h",
                 i, reg_h[i], reg_v[i], bus.rgb_out, reg_exp[i]);
      end
    end
  endtask

  task automatic test_side_enables();
    for (int i = 0; i < 5; i++) begin
      bus.border_en = se_en[i];
      set_in(se_h[i], se_v[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
      cyc(2);
      total++;
      if (bus.rgb_out !== se_exp[i]) begin
        bad++;
        $display("FAIL side_en[%0d] en=%b rgb_out got=%h exp=%h",
                 i, se_en[i], bus.rgb_out, se_exp[i]);
      end
    end
    bus.border_en = 4'hF;
  endtask

  task automatic test_flash();
    bus.border_en = 4'hF;
    set_in(11'd4, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    cyc(2);
    bus.alert = 1'b1;
    cyc(2);
    total++;
    if (bus.rgb_out !== 12'h888) begin
      bad++;
      $display("FAIL flash_before_edge rgb_out got=%h exp=888", bus.rgb_out);
    end
    for (int f = 0; f < 7; f++) begin
      set_in(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
      cyc(2);
      total++;
      if ({bus.frame_tick, bus.vblnk_out} !== 2'b11) begin
        bad++;
        $display("FAIL flash_tick_on[%0d] tick/vblnk got=%b exp=11", f, {bus.frame_tick, bus.vblnk_out});
      end
      cyc(1);
      total++;
      if ({bus.frame_tick, bus.vblnk_out} !== 2'b01) begin
        bad++;
        $display("FAIL flash_tick_off[%0d] tick/vblnk got=%b exp=01", f, {bus.frame_tick, bus.vblnk_out});
      end
      set_in(11'd4, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
      cyc(2);
      total++;
      if (bus.rgb_out !== flash_exp[f]) begin
        bad++;
        $display("FAIL flash_frame[%0d] rgb_out got=%h exp=%h", f, bus.rgb_out, flash_exp[f]);
      end
    end
    bus.alert = 1'b0;
    cyc(2);
    total++;
    if (bus.rgb_out !== 12'hF00) begin
      bad++;
      $display("FAIL flash_drop_midframe rgb_out got=%h exp=f00", bus.rgb_out);
    end
    set_in(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
    cyc(3);
    set_in(11'd791, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    cyc(2);
    total++;
    if ({bus.rgb_out, bus.dbg_state} !== {12'h888, 1'b0}) begin
      bad++;
      $display("FAIL flash_after_drop rgb/state got=%h/%b exp=888/0", bus.rgb_out, bus.dbg_state);
    end
  endtask

  task automatic test_reset_mid_flash();
    bus.border_en = 4'hF;
    bus.alert = 1'b1;
    for (int f = 0; f < 3; f++) begin
      set_in(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
      cyc(3);
      set_in(11'd4, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
      cyc(2);
    end
    total++;
    if ({bus.rgb_out, bus.dbg_phase} !== {12'hF00, 1'b1}) begin
      bad++;
      $display("FAIL pre_reset_phase rgb/phase got=%h/%b exp=f00/1", bus.rgb_out, bus.dbg_phase);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.rgb_out, bus.hcount_out, bus.dbg_state} !== {12'h000, 11'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset rgb/h/state got=%h/%0d/%b exp=000/0/0",
               bus.rgb_out, bus.hcount_out, bus.dbg_state);
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    total++;
    if (bus.rgb_out !== 12'h888) begin
      bad++;
      $display("FAIL post_reset_border rgb_out got=%h exp=888", bus.rgb_out);
    end
    for (int f = 0; f < 3; f++) begin
      set_in(11'd0, 11'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
      cyc(2);
      total++;
      if (bus.frame_tick !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_tick[%0d] got=%b exp=1", f, bus.frame_tick);
      end
      cyc(1);
      set_in(11'd4, 11'd300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
      cyc(2);
      total++;
      if (bus.rgb_out !== ((f == 2) ? 12'hF00 : 12'h888)) begin
        bad++;
        $display("FAIL post_reset_frame[%0d] rgb_out got=%h exp=%h",
                 f, bus.rgb_out, (f == 2) ? 12'hF00 : 12'h888);
      end
    end
    bus.alert = 1'b0;
  endtask

  task automatic test_pipeline();
    logic [10:0] h, v;
    logic        hs, vs, hb, vb, prev_vb;
    logic [11:0] rgb;
    logic [38:0] exp_v, got_v;
    bus.border_en = 4'h0;
    bus.alert = 1'b0;
    prev_vb = 1'b0;
    for (int i = 0; i < 301; i++) begin
      if (i < 300) begin
        h   = 11'($urandom_range(0, 2047));
        v   = 11'($urandom_range(0, 2047));
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        hb  = 1'($urandom_range(0, 1));
        vb  = ((i % 100) >= 90);
        rgb = 12'($urandom_range(0, 4095));
        set_in(h, v, hs, vs, hb, vb, rgb);
        exp_q.push_back({h, v, hs, vs, hb, vb, vb & ~prev_vb, (hb | vb) ? 12'h000 : rgb});
        prev_vb = vb;
      end
      cyc(1);
      if (exp_q.size() == 2 || (i == 300 && exp_q.size() == 1)) begin
        exp_v = exp_q.pop_front();
        got_v = {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                 bus.hblnk_out, bus.vblnk_out, bus.frame_tick, bus.rgb_out};
        total++;
        if (got_v !== exp_v) begin
          bad++;
          $display("FAIL pipeline[%0d] got=%h exp=%h", i, got_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.alert = 1'b0;
    bus.border_en = 4'h0;
    set_in(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    test_reset();
    test_regions();
    test_side_enables();
    test_flash();
    test_reset_mid_flash();
    test_pipeline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
